morse_tx_seq: RTL and testbench

//  Parametrised Morse keyer: serialises one character per handshake onto a 1-bit key line.

---
 rtl/morse_tx_seq.sv | 214 +++++++++++++++++++++
 tb/tb_morse_tx_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/morse_tx_seq.sv
// rtl/morse_tx_seq.sv - Morse keyer: one character per handshake onto a registered key line.
// Optional MORSE_TX_ABORT_EN adds abort_i to cancel a character in flight.
module morse_tx_seq #(
  parameter int   CODE_W         = 16,
  parameter int   LEN_W          = 5,
  parameter int   UNIT_W         = 16,
  parameter int   DOT_UNITS      = 1,
  parameter int   DASH_UNITS     = 3,
  parameter int   GAP_UNITS      = 1,
  parameter int   CHAR_GAP_UNITS = 3,
  parameter logic CODE_DOT       = 1'b0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [UNIT_W-1:0] unit_cycles_i,
  input  logic              valid_i,
`ifdef MORSE_TX_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              ready_o,
  output logic              busy_o,
  output logic              serial_o,
  output logic              done_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXU = max2(max2(DOT_UNITS, DASH_UNITS), max2(GAP_UNITS, CHAR_GAP_UNITS));
  localparam int UCW  = $clog2(MAXU) + 1;

  localparam logic [UCW-1:0]   DOT_M1   = UCW'(DOT_UNITS - 1);
  localparam logic [UCW-1:0]   DASH_M1  = UCW'(DASH_UNITS - 1);
  localparam logic [UCW-1:0]   GAP_M1   = UCW'(GAP_UNITS - 1);
  localparam logic [UCW-1:0]   CGAP_M1  = UCW'(CHAR_GAP_UNITS - 1);
  localparam logic [LEN_W-1:0] CODE_W_L = LEN_W'(CODE_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MARK = 2'd1,
    S_GAP  = 2'd2,
    S_CGAP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    ptr_q, ptr_d;
  logic [UNIT_W-1:0]   unit_q, unit_d;
  logic [UNIT_W-1:0]   cyc_q, cyc_d;
  logic [UCW-1:0]      ucnt_q, ucnt_d;
  logic                serial_q, serial_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic                abort_w;
  logic                last_w;
  logic [UNIT_W-1:0]   u_acc;
  logic [LEN_W-1:0]    l_acc;
  logic [LEN_W-1:0]    ptr_nxt;
  logic [CODE_W-1:0]   code_sh;

  function automatic logic [UCW-1:0] mark_m1(input logic b);
    return (b == CODE_DOT) ? DOT_M1 : DASH_M1;
  endfunction

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    unit_d   = unit_q;
    cyc_d    = cyc_q;
    ucnt_d   = ucnt_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
    busy_d   = busy_q;
`ifdef MORSE_TX_ABORT_EN
    abort_w  = abort_i;
`else
    abort_w  = 1'b0;
`endif
    last_w   = (cyc_q == '0) && (ucnt_q == '0);
    u_acc    = (unit_cycles_i == '0) ? UNIT_W'(1) : unit_cycles_i;
    l_acc    = (len_i > CODE_W_L) ? CODE_W_L : len_i;
    ptr_nxt  = ptr_q + LEN_W'(1);
    code_sh  = code_q >> ptr_nxt;

    // Counters run down to zero; the state ends on the cycle both are zero.
    if (state_q != S_IDLE && !last_w) begin
      if (cyc_q == '0) begin
        cyc_d  = unit_q - UNIT_W'(1);
        ucnt_d = ucnt_q - UCW'(1);
      end else begin
        cyc_d = cyc_q - UNIT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          code_d  = code_i;
          len_d   = l_acc;
          unit_d  = u_acc;
          ptr_d   = '0;
          cyc_d   = u_acc - UNIT_W'(1);
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (l_acc == '0) begin
            state_d  = S_CGAP;
            ucnt_d   = CGAP_M1;
            serial_d = 1'b0;
          end else begin
            state_d  = S_MARK;
            ucnt_d   = mark_m1(code_i[0]);
            serial_d = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (last_w) begin
          serial_d = 1'b0;
          cyc_d    = unit_q - UNIT_W'(1);
          if (ptr_q == len_q - LEN_W'(1)) begin
            state_d = S_CGAP;
            ucnt_d  = CGAP_M1;
          end else begin
            state_d = S_GAP;
            ucnt_d  = GAP_M1;
          end
        end
      end
      S_GAP: begin
        if (last_w) begin
          state_d  = S_MARK;
          ptr_d    = ptr_nxt;
          serial_d = 1'b1;
          cyc_d    = unit_q - UNIT_W'(1);
          ucnt_d   = mark_m1(code_sh[0]);
        end
      end
      S_CGAP: begin
        if (last_w) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          ptr_d   = '0;
          cyc_d   = '0;
          ucnt_d  = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b0;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        ptr_d    = '0;
        cyc_d    = '0;
        ucnt_d   = '0;
      end
    endcase

    if (abort_w && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      serial_d = 1'b0;
      done_d   = 1'b0;
      ready_d  = 1'b1;
      busy_d   = 1'b0;
      ptr_d    = '0;
      cyc_d    = '0;
      ucnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      len_q    <= '0;
      ptr_q    <= '0;
      unit_q   <= '0;
      cyc_q    <= '0;
      ucnt_q   <= '0;
      serial_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      unit_q   <= unit_d;
      cyc_q    <= cyc_d;
      ucnt_q   <= ucnt_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign serial_o = serial_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_morse_tx_seq.sv
// tb/tb_morse_tx_seq.sv - randomized bench for morse_tx_seq against a waveform-level reference model.
module tb_morse_tx_seq;
  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [15:0] code_i = '0;
  logic [4:0]  len_i = '0;
  logic [15:0] unit_cycles_i = '0;
  logic        valid_i = 1'b0;
`ifdef MORSE_TX_ABORT_EN
  logic        abort_i = 1'b0;
`endif
  logic        ready_o, busy_o, serial_o, done_o;

  int errors = 0;
  int checks = 0;

  morse_tx_seq dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .code_i(code_i),
    .len_i(len_i),
    .unit_cycles_i(unit_cycles_i),
    .valid_i(valid_i),
`ifdef MORSE_TX_ABORT_EN
    .abort_i(abort_i),
`endif
    .ready_o(ready_o),
    .busy_o(busy_o),
    .serial_o(serial_o),
    .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected key waveform: marks of 1 or 3 units, 1-unit gaps between them, 3-unit tail gap.
  task automatic run_char(input logic [15:0] c, input logic [4:0] l, input logic [15:0] u,
                          input bit b2b, input logic [15:0] nc, input logic [4:0] nl,
                          input logic [15:0] nu);
    bit q[$];
    int L, U, n;
    L = (l > 5'd16) ? 16 : int'(l);
    U = (u == 16'd0) ? 1 : int'(u);
    for (int i = 0; i < L; i++) begin
      n = (c[i] == 1'b0) ? U : 3 * U;
      repeat (n) q.push_back(1'b1);
      if (i < L - 1) repeat (U) q.push_back(1'b0);
    end
    repeat (3 * U) q.push_back(1'b0);

    code_i = c; len_i = l; unit_cycles_i = u; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    if (b2b) begin
      code_i = nc; len_i = nl; unit_cycles_i = nu;
    end else begin
      valid_i = 1'b0;
      code_i = 16'($urandom); len_i = 5'($urandom); unit_cycles_i = 16'($urandom);
    end
    check("ready_lo", 32'(ready_o), 32'd0);
    check("busy_hi", 32'(busy_o), 32'd1);
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) @(negedge clk_i);
      check("serial", 32'(serial_o), 32'(q[k]));
      check("done_lo", 32'(done_o), 32'd0);
    end
    @(negedge clk_i);
    check("done_pulse", 32'(done_o), 32'd1);
    check("ready_back", 32'(ready_o), 32'd1);
    check("busy_lo", 32'(busy_o), 32'd0);
    check("serial_idle", 32'(serial_o), 32'd0);
  endtask

  logic [15:0] cc, nc;
  logic [4:0]  cl, nl;
  logic [15:0] cu, nu;
  bit          b2b;

  initial begin
    repeat (2) @(negedge clk_i);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_serial", 32'(serial_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    run_char(16'h0000, 5'd1, 16'd2, 1'b0, '0, '0, '0);
    run_char(16'h0002, 5'd4, 16'd1, 1'b0, '0, '0, '0);
    run_char(16'h0001, 5'd1, 16'd0, 1'b0, '0, '0, '0);
    run_char(16'h0005, 5'd0, 16'd2, 1'b0, '0, '0, '0);
    run_char(16'hffff, 5'd31, 16'd1, 1'b0, '0, '0, '0);
    run_char(16'h0006, 5'd3, 16'd1, 1'b1, 16'h0009, 5'd4, 16'd2);
    run_char(16'h0009, 5'd4, 16'd2, 1'b0, '0, '0, '0);

    cc = 16'($urandom); cl = 5'($urandom_range(0, 20)); cu = 16'($urandom_range(0, 3));
    for (int i = 0; i < 25; i++) begin
      nc = 16'($urandom); nl = 5'($urandom_range(0, 20)); nu = 16'($urandom_range(0, 3));
      b2b = bit'($urandom_range(0, 1));
      run_char(cc, cl, cu, b2b, nc, nl, nu);
      if (!b2b) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk_i);
          check("idle_ready", 32'(ready_o), 32'd1);
          check("idle_serial", 32'(serial_o), 32'd0);
        end
      end
      cc = nc; cl = nl; cu = nu;
    end

    // Reset in the middle of a dash.
    code_i = 16'h0001; len_i = 5'd1; unit_cycles_i = 16'd4; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("dash_mid", 32'(serial_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    check("rst_mid_serial", 32'(serial_o), 32'd0);
    check("rst_mid_ready", 32'(ready_o), 32'd1);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (15) begin
      @(negedge clk_i);
      check("rst_no_done", 32'(done_o), 32'd0);
      check("rst_quiet", 32'(serial_o), 32'd0);
    end

`ifdef MORSE_TX_ABORT_EN
    code_i = 16'h0000; len_i = 5'd2; unit_cycles_i = 16'd3; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("gap_entered", 32'(serial_o), 32'd0);
    check("gap_busy", 32'(busy_o), 32'd1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    repeat (10) begin
      @(negedge clk_i);
      check("abort_quiet", 32'(serial_o | done_o), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
